// File: rtl/delay_timer.sv
// Prescaled, runtime-loadable down-counter: done pulses count*PRESCALE clocks after start, or at the same edge when count==0.
// Periodic mode auto-reloads. There is no backpressure: abort beats start, start beats tick, and start retriggers while running.
module delay_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] count,
    input  logic             periodic,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] reload;
    logic             mode;

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            presc     <= '0;
            reload    <= '0;
            mode      <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                remaining <= '0;
                presc     <= '0;
            end else if (start) begin
                reload <= count;
                mode   <= periodic;
                presc  <= '0;
                if (count != '0) begin
                    remaining <= count;
                    state     <= RUN;
                end else begin
                    // Zero-length delay completes on the start edge itself.
                    done      <= 1'b1;
                    remaining <= '0;
                    state     <= IDLE;
                end
            end else if (state == RUN) begin
                if (presc == PMAX) begin
                    presc <= '0;
                    if (remaining == WIDTH'(1)) begin
                        done <= 1'b1;
                        if (mode) begin
                            remaining <= reload;
                        end else begin
                            remaining <= '0;
                            state     <= IDLE;
                        end
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule
